// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: shared period counter, per-channel duty, debounced keys and a serial threshold engine.
// Optional build macro PWM_CENTER_ALIGN_EN selects up/down centre-aligned counting.

module PwmKeyDebounce #(
   parameter int CYCLES = 1000000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic key_ni,
   output logic press_o
);

   localparam int DB_W = $clog2(CYCLES + 1);
   localparam logic [DB_W-1:0] LAST = DB_W'(CYCLES - 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_PRESS   = 2'd1;
   localparam logic [1:0] ST_HELD    = 2'd2;
   localparam logic [1:0] ST_RELEASE = 2'd3;

   logic [1:0]      syncQ;
   logic [1:0]      stateQ, stateD;
   logic [DB_W-1:0] cntQ, cntD;
   logic            pressQ, pressD;
   logic            down;

   assign down    = ~syncQ[1];
   assign press_o = pressQ;

   // A bounce during either wait window falls back to the last stable state
   always_comb begin
      stateD = stateQ;
      cntD   = cntQ;
      pressD = 1'b0;
      case (stateQ)
         ST_IDLE: begin
            if (down) begin
               stateD = ST_PRESS;
               cntD   = '0;
            end
         end
         ST_PRESS: begin
            if (!down) begin
               stateD = ST_IDLE;
               cntD   = '0;
            end else if (cntQ == LAST) begin
               stateD = ST_HELD;
               cntD   = '0;
               pressD = 1'b1;
            end else begin
               cntD = cntQ + 1'b1;
            end
         end
         ST_HELD: begin
            if (!down) begin
               stateD = ST_RELEASE;
               cntD   = '0;
            end
         end
         default: begin
            if (down) begin
               stateD = ST_HELD;
               cntD   = '0;
            end else if (cntQ == LAST) begin
               stateD = ST_IDLE;
               cntD   = '0;
            end else begin
               cntD = cntQ + 1'b1;
            end
         end
      endcase
   end

   // The synchroniser resets to the released key level
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         syncQ  <= 2'b11;
         stateQ <= ST_IDLE;
         cntQ   <= '0;
         pressQ <= 1'b0;
      end else begin
         syncQ  <= {syncQ[0], key_ni};
         stateQ <= stateD;
         cntQ   <= cntD;
         pressQ <= pressD;
      end
   end

endmodule

module pwm_multi_channel #(
   parameter int CHANNELS        = 4,
   parameter int CNT_W           = 24,
   parameter int DEFAULT_PERIOD  = 50000,
   parameter int DEFAULT_DUTY    = 50,
   parameter int PERIOD_STEP     = 5000,
   parameter int PERIOD_MIN      = 100,
   parameter int PERIOD_MAX      = 1000000,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic                CLK,
   input  logic                RSTn,
   input  logic                SelCh_In,
   input  logic                AddDuty_In,
   input  logic                SubDuty_In,
   input  logic                AddPeriod_In,
   input  logic                SubPeriod_In,
   output logic [CHANNELS-1:0] PWM_Out,
   output logic [2:0]          Sel_Ch,
   output logic [6:0]          Duty,
   output logic [CNT_W-1:0]    Count_P,
   output logic [CNT_W-1:0]    Count_D,
   output logic                Busy
);

   localparam int SEL_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int PROD_W = CNT_W + 7;
   localparam int STEP_W = $clog2(PROD_W);

   localparam logic [CNT_W-1:0]  RESET_PERIOD = CNT_W'(DEFAULT_PERIOD);
   localparam logic [CNT_W-1:0]  RESET_THR    = CNT_W'(DEFAULT_PERIOD * DEFAULT_DUTY / 100);
   localparam logic [6:0]        RESET_DUTY   = 7'(DEFAULT_DUTY);
   localparam logic [CNT_W-1:0]  P_MIN        = CNT_W'(PERIOD_MIN);
   localparam logic [CNT_W-1:0]  P_MAX        = CNT_W'(PERIOD_MAX);
   localparam logic [CNT_W-1:0]  P_STEP       = CNT_W'(PERIOD_STEP);
   localparam logic [SEL_W-1:0]  LAST_CH      = SEL_W'(CHANNELS - 1);
   localparam logic [STEP_W-1:0] MUL_LAST     = STEP_W'(6);
   localparam logic [STEP_W-1:0] DIV_LAST     = STEP_W'(PROD_W - 1);

   localparam logic [1:0] ENG_IDLE = 2'd0;
   localparam logic [1:0] ENG_MUL  = 2'd1;
   localparam logic [1:0] ENG_DIV  = 2'd2;
   localparam logic [1:0] ENG_DONE = 2'd3;

   logic [4:0] keyN, keyEv;
   logic       evSel, evAddDuty, evSubDuty, evAddP, evSubP;

   assign keyN = {SubPeriod_In, AddPeriod_In, SubDuty_In, AddDuty_In, SelCh_In};
   assign {evSubP, evAddP, evSubDuty, evAddDuty, evSel} = keyEv;

   for (genvar k = 0; k < 5; k++) begin : g_key
      PwmKeyDebounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk_i   (CLK),
         .rst_ni  (RSTn),
         .key_ni  (keyN[k]),
         .press_o (keyEv[k])
      );
   end

   logic [SEL_W-1:0]    selQ, selD;
   logic [6:0]          dutyQ [CHANNELS];
   logic [6:0]          dutyD [CHANNELS];
   logic [CNT_W-1:0]    shadowPeriodQ, shadowPeriodD;
   logic [CNT_W-1:0]    activePeriodQ;
   logic [CNT_W-1:0]    thrShadowQ [CHANNELS];
   logic [CNT_W-1:0]    thrShadowD [CHANNELS];
   logic [CNT_W-1:0]    thrActiveQ [CHANNELS];
   logic [CHANNELS-1:0] pendingQ, pendingD, setMask;
   logic [1:0]          engQ, engD;
   logic [SEL_W-1:0]    chQ, chD, pickIdx;
   logic [PROD_W-1:0]   accQ, accD, mcandQ, mcandD;
   logic [6:0]          mplierQ, mplierD;
   logic [6:0]          remQ, remD;
   logic [7:0]          remShift;
   logic [STEP_W-1:0]   stepQ, stepD;
   logic                reArmQ, reArmD;
   logic [CNT_W-1:0]    cntQ;
   logic [CHANNELS-1:0] hit, pwmQ;
   logic                ready;

   // Key events act in the cycle they arrive; saturated presses leave everything untouched
   always_comb begin
      selD          = selQ;
      dutyD         = dutyQ;
      shadowPeriodD = shadowPeriodQ;
      setMask       = '0;
      if (evAddDuty && !evSubDuty && dutyQ[selQ] < 7'd100) begin
         dutyD[selQ]   = dutyQ[selQ] + 7'd1;
         setMask[selQ] = 1'b1;
      end else if (evSubDuty && !evAddDuty && dutyQ[selQ] != 7'd0) begin
         dutyD[selQ]   = dutyQ[selQ] - 7'd1;
         setMask[selQ] = 1'b1;
      end
      if (evAddP && !evSubP && shadowPeriodQ < P_MAX) begin
         shadowPeriodD = (({1'b0, shadowPeriodQ} + {1'b0, P_STEP}) >= {1'b0, P_MAX}) ?
                         P_MAX : shadowPeriodQ + P_STEP;
         setMask       = '1;
      end else if (evSubP && !evAddP && shadowPeriodQ > P_MIN) begin
         shadowPeriodD = ({1'b0, shadowPeriodQ} <= ({1'b0, P_MIN} + {1'b0, P_STEP})) ?
                         P_MIN : shadowPeriodQ - P_STEP;
         setMask       = '1;
      end
      if (evSel) begin
         selD = (selQ == LAST_CH) ? '0 : selQ + 1'b1;
      end
   end

   always_comb begin
      pickIdx = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (pendingQ[i]) begin
            pickIdx = SEL_W'(i);
         end
      end
   end

   // A change landing on the channel being computed re-arms it so DONE leaves its pending bit set
   always_comb begin
      engD       = engQ;
      chD        = chQ;
      accD       = accQ;
      mcandD     = mcandQ;
      mplierD    = mplierQ;
      remD       = remQ;
      stepD      = stepQ;
      reArmD     = reArmQ;
      thrShadowD = thrShadowQ;
      pendingD   = pendingQ | setMask;
      remShift   = {remQ, accQ[PROD_W-1]};
      case (engQ)
         ENG_IDLE: begin
            if (|pendingQ) begin
               engD    = ENG_MUL;
               chD     = pickIdx;
               accD    = '0;
               mcandD  = PROD_W'(shadowPeriodQ);
               mplierD = dutyQ[pickIdx];
               stepD   = '0;
               reArmD  = setMask[pickIdx];
            end
         end
         ENG_MUL: begin
            if (mplierQ[0]) begin
               accD = accQ + mcandQ;
            end
            mcandD  = mcandQ << 1;
            mplierD = mplierQ >> 1;
            if (stepQ == MUL_LAST) begin
               engD  = ENG_DIV;
               stepD = '0;
               remD  = '0;
            end else begin
               stepD = stepQ + 1'b1;
            end
         end
         ENG_DIV: begin
            if (remShift >= 8'd100) begin
               remD = 7'(remShift - 8'd100);
               accD = {accQ[PROD_W-2:0], 1'b1};
            end else begin
               remD = remShift[6:0];
               accD = {accQ[PROD_W-2:0], 1'b0};
            end
            if (stepQ == DIV_LAST) begin
               engD = ENG_DONE;
            end else begin
               stepD = stepQ + 1'b1;
            end
         end
         default: begin
            thrShadowD[chQ] = accQ[CNT_W-1:0];
            if (!reArmQ && !setMask[chQ]) begin
               pendingD[chQ] = 1'b0;
            end
            engD = ENG_IDLE;
         end
      endcase
      if (engQ != ENG_IDLE && setMask[chQ]) begin
         reArmD = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         selQ          <= '0;
         shadowPeriodQ <= RESET_PERIOD;
         pendingQ      <= '0;
         engQ          <= ENG_IDLE;
         chQ           <= '0;
         accQ          <= '0;
         mcandQ        <= '0;
         mplierQ       <= '0;
         remQ          <= '0;
         stepQ         <= '0;
         reArmQ        <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            dutyQ[i]      <= RESET_DUTY;
            thrShadowQ[i] <= RESET_THR;
         end
      end else begin
         selQ          <= selD;
         dutyQ         <= dutyD;
         shadowPeriodQ <= shadowPeriodD;
         pendingQ      <= pendingD;
         engQ          <= engD;
         chQ           <= chD;
         accQ          <= accD;
         mcandQ        <= mcandD;
         mplierQ       <= mplierD;
         remQ          <= remD;
         stepQ         <= stepD;
         reArmQ        <= reArmD;
         thrShadowQ    <= thrShadowD;
      end
   end

   // Loads gate on the engine alone; the period mismatch term only reports that a load is still due
   assign ready = (engQ == ENG_IDLE) && !(|pendingQ);
   assign Busy  = !ready || (shadowPeriodQ != activePeriodQ);

`ifdef PWM_CENTER_ALIGN_EN
   logic dirQ;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         cntQ          <= '0;
         dirQ          <= 1'b0;
         activePeriodQ <= RESET_PERIOD;
         for (int i = 0; i < CHANNELS; i++) begin
            thrActiveQ[i] <= RESET_THR;
         end
      end else if (!dirQ) begin
         if (cntQ >= activePeriodQ - 1'b1) begin
            dirQ <= 1'b1;
         end else begin
            cntQ <= cntQ + 1'b1;
         end
      end else if (cntQ == '0) begin
         dirQ <= 1'b0;
         if (ready) begin
            activePeriodQ <= shadowPeriodQ;
            thrActiveQ    <= thrShadowQ;
         end
      end else begin
         cntQ <= cntQ - 1'b1;
      end
   end

   // High while cnt >= period - thr, so the pulse straddles the top turn-around
   always_comb begin
      hit = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         hit[i] = ({1'b0, cntQ} + {1'b0, thrActiveQ[i]}) >= {1'b0, activePeriodQ};
      end
   end
`else
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         cntQ          <= '0;
         activePeriodQ <= RESET_PERIOD;
         for (int i = 0; i < CHANNELS; i++) begin
            thrActiveQ[i] <= RESET_THR;
         end
      end else if (cntQ >= activePeriodQ - 1'b1) begin
         cntQ <= '0;
         if (ready) begin
            activePeriodQ <= shadowPeriodQ;
            thrActiveQ    <= thrShadowQ;
         end
      end else begin
         cntQ <= cntQ + 1'b1;
      end
   end

   always_comb begin
      hit = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         hit[i] = cntQ < thrActiveQ[i];
      end
   end
`endif

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         pwmQ <= '0;
      end else begin
         pwmQ <= hit;
      end
   end

   assign PWM_Out = pwmQ;
   assign Sel_Ch  = 3'(selQ);
   assign Duty    = dutyQ[selQ];
   assign Count_P = activePeriodQ;
   assign Count_D = thrActiveQ[selQ];

endmodule
